// File: rtl/vending_ctrl.sv
// ============================================================================
// Module   : vending_ctrl
// Brief    : Coin-credit vending controller with dispense handshake, change
//            pulse payout, overflow/busy coin rejection. Optional cancel/refund
//            path enabled by defining VEND_CANCEL_EN.
// Revision : 1.0 - initial parametrised release
// ============================================================================
`default_nettype none

module vending_ctrl #(
    parameter int CREDIT_W   = 4,
    parameter int PRICE      = 6,
    parameter int COIN0_VAL  = 1,
    parameter int COIN1_VAL  = 2,
    parameter int COIN2_VAL  = 4,
    parameter int MAX_CREDIT = 12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                coin_valid,
    input  logic [1:0]          coin_sel,
    input  logic                cancel,
    input  logic                dispense_ack,
    output logic [CREDIT_W-1:0] credit,
    output logic                dispense,
    output logic                change_pulse,
    output logic                coin_reject,
    output logic [1:0]          state,
    output logic                busy
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_COLLECT  = 2'd1;
    localparam logic [1:0] S_DISPENSE = 2'd2;
    localparam logic [1:0] S_CHANGE   = 2'd3;

    localparam logic [CREDIT_W:0]   c_PRICE_X = (CREDIT_W+1)'(PRICE);
    localparam logic [CREDIT_W:0]   c_MAX_X   = (CREDIT_W+1)'(MAX_CREDIT);
    localparam logic [CREDIT_W-1:0] c_PRICE   = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] c_ONE     = CREDIT_W'(1);

`ifdef VEND_CANCEL_EN
    localparam logic c_CANCEL_EN = 1'b1;
`else
    localparam logic c_CANCEL_EN = 1'b0;
`endif

    logic [1:0]          r_state;
    logic [CREDIT_W-1:0] r_credit;
    logic                r_phase;
    logic                r_coin_reject;

    logic [1:0]          w_state_nxt;
    logic [CREDIT_W-1:0] w_credit_nxt;
    logic                w_phase_nxt;
    logic                w_accept;
    logic                w_reject_nxt;
    logic                w_cancel_req;
    logic                w_coin_legal;
    logic [CREDIT_W-1:0] w_coin_val;
    logic [CREDIT_W:0]   w_sum;

    always_comb begin
        w_coin_val   = '0;
        w_coin_legal = 1'b1;
        case (coin_sel)
            2'd0:    w_coin_val = CREDIT_W'(COIN0_VAL);
            2'd1:    w_coin_val = CREDIT_W'(COIN1_VAL);
            2'd2:    w_coin_val = CREDIT_W'(COIN2_VAL);
            default: w_coin_legal = 1'b0;
        endcase
    end

    // Extra bit keeps the overflow compare honest when credit+val wraps CREDIT_W.
    assign w_sum        = {1'b0, r_credit} + {1'b0, w_coin_val};
    assign w_cancel_req = c_CANCEL_EN && cancel && (r_state == S_COLLECT);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_credit      <= '0;
            r_phase       <= 1'b0;
            r_coin_reject <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_credit      <= w_credit_nxt;
            r_phase       <= w_phase_nxt;
            r_coin_reject <= w_reject_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt  = r_state;
        w_credit_nxt = r_credit;
        w_phase_nxt  = r_phase;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE, S_COLLECT: begin
                if (w_cancel_req) begin
                    w_state_nxt = S_CHANGE;
                    w_phase_nxt = 1'b0;
                end else if (coin_valid && w_coin_legal && (w_sum <= c_MAX_X)) begin
                    w_accept     = 1'b1;
                    w_credit_nxt = w_sum[CREDIT_W-1:0];
                    w_state_nxt  = (w_sum >= c_PRICE_X) ? S_DISPENSE : S_COLLECT;
                end
            end
            S_DISPENSE: begin
                if (dispense_ack) begin
                    w_credit_nxt = r_credit - c_PRICE;
                    w_state_nxt  = (r_credit != c_PRICE) ? S_CHANGE : S_IDLE;
                    w_phase_nxt  = 1'b0;
                end
            end
            S_CHANGE: begin
                // phase 0 is the pulse-high cycle; that edge spends one unit.
                if (!r_phase) begin
                    w_credit_nxt = r_credit - c_ONE;
                    if (r_credit == c_ONE) begin
                        w_state_nxt = S_IDLE;
                        w_phase_nxt = 1'b0;
                    end else begin
                        w_phase_nxt = 1'b1;
                    end
                end else begin
                    w_phase_nxt = 1'b0;
                end
            end
            default: ;
        endcase
        w_reject_nxt = coin_valid && !w_accept;
    end

    // Output decode, registers only
    always_comb begin
        credit       = r_credit;
        state        = r_state;
        coin_reject  = r_coin_reject;
        dispense     = (r_state == S_DISPENSE);
        change_pulse = (r_state == S_CHANGE) && !r_phase;
        busy         = r_state[1];
    end

endmodule

`default_nettype wire

// File: doc/vending_ctrl.md
# vending_ctrl

Parametrised coin-credit vending controller: accumulates coin credit, raises a dispense request when credit reaches the price, and pays out the remaining credit as countable change pulses. It is the next generation of the team's fixed 3-bit vending FSM. It adds configurable coin values, price and credit width, a dispense handshake with the mechanism, and credit overflow and busy rejection. It sits between the coin acceptor front end and the dispense and change actuators.

## Interface
- CREDIT_W, 4, width of credit register and value parameters (units of one change coin)
- PRICE, 6, product price in units; 1 ≤ PRICE ≤ MAX_CREDIT
- COIN0_VAL, 1, value of coin_sel=0
- COIN1_VAL, 2, value of coin_sel=1
- COIN2_VAL, 4, value of coin_sel=2
- MAX_CREDIT, 12, highest credit accepted; must be < 2^CREDIT_W
- clk  in  1  clock, all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- coin_valid  in  1  one-cycle strobe, coin present
- coin_sel  in  2  coin type; 3 is illegal
- cancel  in  1  refund request (see Configuration)
- dispense_ack  in  1  mechanism has delivered the product
- credit  out  CREDIT_W  current credit register
- dispense  out  1  dispense request, level
- change_pulse  out  1  one pulse = one unit of change
- coin_reject  out  1  one-cycle pulse, last coin returned
- state  out  2  0 IDLE, 1 COLLECT, 2 DISPENSE, 3 CHANGE
- busy  out  1  high in DISPENSE or CHANGE

## Operation
- Reset: state=IDLE, credit=0, phase=0, coin_reject=0. This gives dispense=0, change_pulse=0, busy=0.
- dispense = (state==DISPENSE). change_pulse = (state==CHANGE && phase==0). busy = state[1]. All three are decoded from registers only.
- Coin accept (IDLE/COLLECT, coin_valid=1, coin_sel≠3, credit+val ≤ MAX_CREDIT):
  - credit ← credit+val, using a CREDIT_W+1-bit sum for the compare.
  - If the new credit ≥ PRICE, state ← DISPENSE. Otherwise state ← COLLECT.
- Coin reject: coin_valid=1 with coin_sel=3, or overflow, or state DISPENSE/CHANGE. Credit and state are unchanged; coin_reject=1 on the following cycle only.
- DISPENSE: holds until dispense_ack=1. On that edge credit ← credit−PRICE; state ← CHANGE if the remainder > 0, else IDLE. dispense_ack outside DISPENSE is ignored.
- CHANGE:
  - phase toggles every cycle.
  - On each edge with change_pulse=1, credit ← credit−1.
  - The edge that takes credit to 0 also sets state ← IDLE and phase ← 0.
  - Result: R units give R pulses, each one cycle high with one cycle low between them.
- Cancel (macro on only): accepted only in COLLECT, which means credit > 0. It sets state ← CHANGE, phase ← 0, and refunds the full credit. Cancel and coin in the same cycle: cancel wins and the coin is rejected. Cancel in other states is ignored.

## Timing
- Coin to credit update: 1 edge. Coin to dispense high: the same edge.
- dispense_ack to dispense low: 1 edge. Change starts on the next cycle with change_pulse=1.
- coin_reject asserts 1 cycle after the rejected strobe and lasts 1 cycle.
- Change of R units: IDLE is re-entered 2R−1 cycles after CHANGE is entered.
- Reset mid-operation clears state and outputs immediately (asynchronous). Any pending credit is lost and no change is paid.

## Configuration
- VEND_CANCEL_EN defined: the cancel/refund path operates as described above.
- Not defined: the cancel port is still present but ignored. COLLECT exits only through a coin that reaches the price.

## Test plan
- Reset, coins 2 (4) then 1 (2) → credit 4 then 6, dispense=1. Ack → IDLE, credit 0, no change_pulse.
- Coins 2, 2 → credit 8, dispense. Ack → credit 2, two change_pulses separated by one low cycle. IDLE after 3 cycles, credit 0.
- MAX_CREDIT=7: coin 2 (credit 4), coin 2 → coin_reject pulse, credit stays 4, state COLLECT. coin_sel=3 → coin_reject, no change.
- Coin during DISPENSE and during CHANGE → coin_reject each time, credit trajectory unaffected.
- VEND_CANCEL_EN: coins 0, 1 (credit 3), cancel → 3 change_pulses, credit 0, IDLE. Cancel and coin in the same cycle → refund, coin rejected. Without the macro: cancel has no effect.
- rst asserted mid-CHANGE with credit 2 → state 0, credit 0, change_pulse 0 immediately. Normal operation resumes after release.
